param_dump_sequencer: RTL and testbench
=======================================

Name: param_dump_sequencer

Overview:
- Readback counterpart of the SysEx write-side bank address decoder.
- On request, walks every patch parameter bank (env, osc, m1, m2, com), reads each parameter location, and streams the values out as one SysEx dump message.
- Sits between the parameter banks' read ports and the MIDI byte transmitter.
- Uses a valid/ready byte handshake toward the transmitter.

Parameters:
- ADR_W, 6: width of parameter address within a bank.
- BANK_DEPTH, 64: parameters per bank. Must be ≤ 2^ADR_W.
- READ_LAT, 2: cycles from rd_en assertion to valid rd_data, range 1..7.
- MFR_ID, 8'h7D: manufacturer ID byte sent after F0.

Ports:
- CLOCK_25, input, 1: system clock. All logic on rising edge.
- reset_reg, input, 1: synchronous active-high reset.
- dump_req, input, 1: single-cycle start pulse.
- abort, input, 1: single-cycle request to terminate the dump early.
- rd_bank_adr, output, 3: bank code being read: 0 env, 1 osc, 2 m1, 3 m2, 5 com.
- rd_adr, output, ADR_W: parameter address within the bank.
- rd_en, output, 1: read strobe, high for the whole read window.
- env_sel, output, 1: one-hot read select for bank code 0. Valid only while rd_en is high, otherwise 0.
- osc_sel, output, 1: one-hot read select for bank code 1. Same validity rule.
- m1_sel, output, 1: one-hot read select for bank code 2. Same validity rule.
- m2_sel, output, 1: one-hot read select for bank code 3. Same validity rule.
- com_sel, output, 1: one-hot read select for bank code 5. Same validity rule.
- rd_data, input, 7: parameter value returned by the selected bank.
- tx_byte, output, 8: byte to the MIDI transmitter.
- tx_valid, output, 1: tx_byte is valid.
- tx_ready, input, 1: transmitter accepts tx_byte this cycle.
- busy, output, 1: dump in progress (state != IDLE).
- done, output, 1: one-cycle pulse when the final F7 byte is accepted.

Behaviour:
- Reset values: every output is 0; state is IDLE; bank index is 0; address is 0; latency counter is 0.
- Reset mid-dump applies on the next edge: tx_valid drops and no further bytes are sent.

Bank order:
- env(0), osc(1), m1(2), m2(3), com(5).
- Codes 4, 6 and 7 are never issued.

State machine:
- IDLE
  - Stays here until dump_req.
  - dump_req → SOF.
- SOF
  - tx_byte = F0, tx_valid = 1.
  - On handshake → HDR.
- HDR
  - tx_byte = MFR_ID.
  - On handshake → BNK.
- BNK
  - tx_byte = {5'b0, bank code}.
  - On handshake: rd_adr = 0 → RD.
- RD
  - rd_en = 1; the select matching the current bank is high.
  - Counts READ_LAT cycles.
  - On the last count, captures rd_data into the data register → DAT.
  - rd_en and the select deassert when leaving RD.
- DAT
  - tx_byte = {1'b0, captured data}.
  - On handshake with rd_adr < BANK_DEPTH-1: rd_adr + 1 → RD.
  - On handshake with rd_adr = BANK_DEPTH-1 and bank is not com: advance bank → BNK.
  - On handshake with bank = com: → EOF.
- EOF
  - tx_byte = F7.
  - On handshake: pulse done → IDLE.

Handshake rules:
- A byte transfers on the edge where tx_valid and tx_ready are both 1.
- While tx_valid = 1 and tx_ready = 0, tx_byte is held stable and tx_valid stays high.
- After a handshake, tx_valid is low for at least one cycle only in the RD transition. In SOF/HDR/BNK/EOF sequences the next byte is presented on the following cycle.

Timing:
- Minimum cycles per data byte with tx_ready tied high = READ_LAT + 1.
- Total bytes per complete dump = 3 + 5 × (1 + BANK_DEPTH) = 328 at the defaults.

Data width:
- Data bytes always have bit 7 = 0.
- Only rd_data[6:0] is used.

Boundary conditions:
- dump_req while busy: ignored.
- dump_req on the same cycle as done: ignored. A new request is accepted only in IDLE.
- abort while busy: latched. Takes effect at the next handshake of the current byte, or immediately if in RD: the RD read is discarded, tx_valid stays 0 until EOF, and the machine goes to EOF. F7 is always sent so the SysEx frame is closed.
- abort in IDLE, SOF or EOF: ignored.
- abort together with dump_req in IDLE: dump_req wins, abort is ignored.
- rd_adr wrap: never wraps. It resets to 0 in BNK.

Test Plan:
- Basic dump: reset, tx_ready=1, bank model returns data = {bank[2:0], adr[3:0]} & 7F, one dump_req.
  - Exactly 328 bytes.
  - Sequence is F0, 7D, 00, 00, 01, … 0F, 00 …, the com header 05, …, F7.
  - done pulses once; busy drops the cycle after.
- Select check: monitor env_sel..com_sel and rd_bank_adr during RD.
  - Exactly one select is high and it matches the bank code.
  - Code 4 never appears.
  - All selects are 0 outside RD.
- Backpressure: tx_ready random 30% high.
  - Byte stream is identical to the basic dump.
  - tx_byte never changes while tx_valid=1 and tx_ready=0.
- Abort mid-bank: abort while reading osc adr 10.
  - Last data byte sent is for osc adr 9 or 10; the next byte is F7; done pulses.
  - No further rd_en afterwards.
- Re-trigger and reset: dump_req pulsed again at byte 50 → ignored and the stream is unaffected. reset_reg at byte 100 → next cycle all outputs are 0.
  - A following dump_req produces a full 328-byte dump starting with F0.
- Latency sweep: READ_LAT=1 and 7 with tx_ready=1.
  - Per-data-byte spacing is 2 and 8 cycles respectively.
  - Captured values are correct.

Source files
------------

// File: rtl/param_dump_sequencer.sv
// Parameter readback sequencer: walks the env/osc/m1/m2/com banks and streams
// every parameter out as one SysEx dump message over a valid/ready byte link.
module param_dump_sequencer #(
    parameter int         ADR_W      = 6,
    parameter int         BANK_DEPTH = 64,
    parameter int         READ_LAT   = 2,
    parameter logic [7:0] MFR_ID     = 8'h7D
) (
    input  logic             CLOCK_25,
    input  logic             reset_reg,
    input  logic             dump_req,
    input  logic             abort,
    output logic [2:0]       rd_bank_adr,
    output logic [ADR_W-1:0] rd_adr,
    output logic             rd_en,
    output logic             env_sel,
    output logic             osc_sel,
    output logic             m1_sel,
    output logic             m2_sel,
    output logic             com_sel,
    input  logic [6:0]       rd_data,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SOF  = 3'd1,
        S_HDR  = 3'd2,
        S_BNK  = 3'd3,
        S_RD   = 3'd4,
        S_DAT  = 3'd5,
        S_EOF  = 3'd6
    } state_t;

    localparam logic [7:0]       SOF_BYTE  = 8'hF0;
    localparam logic [7:0]       EOF_BYTE  = 8'hF7;
    localparam logic [ADR_W-1:0] LAST_ADR  = ADR_W'(BANK_DEPTH - 1);
    localparam logic [2:0]       LAT_LAST  = 3'(READ_LAT - 1);
    localparam logic [2:0]       LAST_BANK = 3'd4;

    // Bank walk order maps index 0..4 onto codes 0,1,2,3,5; code 4 is skipped.
    function automatic logic [2:0] bank_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'd0;
            3'd1:    code = 3'd1;
            3'd2:    code = 3'd2;
            3'd3:    code = 3'd3;
            3'd4:    code = 3'd5;
            default: code = 3'd0;
        endcase
        return code;
    endfunction

    // One-hot select vector ordered {com, m2, m1, osc, env}.
    function automatic logic [4:0] bank_sel(input logic [2:0] code);
        logic [4:0] sel;
        case (code)
            3'd0:    sel = 5'b00001;
            3'd1:    sel = 5'b00010;
            3'd2:    sel = 5'b00100;
            3'd3:    sel = 5'b01000;
            3'd5:    sel = 5'b10000;
            default: sel = 5'b00000;
        endcase
        return sel;
    endfunction

    state_t     state_r;
    logic [2:0] bank_idx_r;
    logic [2:0] lat_cnt_r;
    logic       abort_pend_r;

    logic       hs_s;
    logic       abort_now_s;
    logic [2:0] cur_code_s;
    logic [2:0] next_code_s;

    // Handshake qualifier and the effective abort (fresh pulse or one latched earlier).
    always_comb begin
        hs_s        = tx_valid & tx_ready;
        abort_now_s = abort | abort_pend_r;
        cur_code_s  = bank_code(bank_idx_r);
        next_code_s = bank_code(bank_idx_r + 3'd1);
    end

    // Dump sequencer: state, read port and transmit byte are all registered here.
    always_ff @(posedge CLOCK_25) begin
        if (reset_reg) begin
            state_r      <= S_IDLE;
            bank_idx_r   <= 3'd0;
            lat_cnt_r    <= 3'd0;
            abort_pend_r <= 1'b0;
            rd_bank_adr  <= 3'd0;
            rd_adr       <= '0;
            rd_en        <= 1'b0;
            {com_sel, m2_sel, m1_sel, osc_sel, env_sel} <= 5'b00000;
            tx_byte      <= 8'h00;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // The done cycle is already IDLE, so a request there must be refused.
                    if (dump_req && !done) begin
                        state_r      <= S_SOF;
                        tx_byte      <= SOF_BYTE;
                        tx_valid     <= 1'b1;
                        busy         <= 1'b1;
                        bank_idx_r   <= 3'd0;
                        rd_bank_adr  <= bank_code(3'd0);
                        rd_adr       <= '0;
                        abort_pend_r <= 1'b0;
                    end else begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                S_SOF: begin
                    if (hs_s) begin
                        state_r <= S_HDR;
                        tx_byte <= MFR_ID;
                    end
                end
                S_HDR: begin
                    if (hs_s && abort_now_s) begin
                        state_r      <= S_EOF;
                        tx_byte      <= EOF_BYTE;
                        abort_pend_r <= 1'b0;
                    end else if (hs_s) begin
                        state_r <= S_BNK;
                        tx_byte <= {5'b00000, cur_code_s};
                    end else begin
                        abort_pend_r <= abort_now_s;
                    end
                end
                S_BNK: begin
                    if (hs_s && abort_now_s) begin
                        state_r      <= S_EOF;
                        tx_byte      <= EOF_BYTE;
                        abort_pend_r <= 1'b0;
                    end else if (hs_s) begin
                        state_r   <= S_RD;
                        rd_adr    <= '0;
                        rd_en     <= 1'b1;
                        {com_sel, m2_sel, m1_sel, osc_sel, env_sel} <= bank_sel(cur_code_s);
                        tx_valid  <= 1'b0;
                        lat_cnt_r <= 3'd0;
                    end else begin
                        abort_pend_r <= abort_now_s;
                    end
                end
                S_RD: begin
                    if (abort_now_s) begin
                        // Discard the read in flight and close the frame straight away.
                        state_r      <= S_EOF;
                        rd_en        <= 1'b0;
                        {com_sel, m2_sel, m1_sel, osc_sel, env_sel} <= 5'b00000;
                        tx_byte      <= EOF_BYTE;
                        tx_valid     <= 1'b1;
                        abort_pend_r <= 1'b0;
                    end else if (lat_cnt_r == LAT_LAST) begin
                        state_r  <= S_DAT;
                        rd_en    <= 1'b0;
                        {com_sel, m2_sel, m1_sel, osc_sel, env_sel} <= 5'b00000;
                        tx_byte  <= {1'b0, rd_data};
                        tx_valid <= 1'b1;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 3'd1;
                    end
                end
                S_DAT: begin
                    if (hs_s && abort_now_s) begin
                        state_r      <= S_EOF;
                        tx_byte      <= EOF_BYTE;
                        abort_pend_r <= 1'b0;
                    end else if (hs_s && (rd_adr != LAST_ADR)) begin
                        state_r   <= S_RD;
                        rd_adr    <= rd_adr + ADR_W'(1);
                        rd_en     <= 1'b1;
                        {com_sel, m2_sel, m1_sel, osc_sel, env_sel} <= bank_sel(cur_code_s);
                        tx_valid  <= 1'b0;
                        lat_cnt_r <= 3'd0;
                    end else if (hs_s && (bank_idx_r != LAST_BANK)) begin
                        state_r     <= S_BNK;
                        bank_idx_r  <= bank_idx_r + 3'd1;
                        rd_bank_adr <= next_code_s;
                        tx_byte     <= {5'b00000, next_code_s};
                    end else if (hs_s) begin
                        state_r <= S_EOF;
                        tx_byte <= EOF_BYTE;
                    end else begin
                        abort_pend_r <= abort_now_s;
                    end
                end
                S_EOF: begin
                    if (hs_s) begin
                        state_r      <= S_IDLE;
                        tx_valid     <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        abort_pend_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    rd_en    <= 1'b0;
                    {com_sel, m2_sel, m1_sel, osc_sel, env_sel} <= 5'b00000;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_dump_sequencer.sv
// Directed bench for param_dump_sequencer: full dumps, backpressure, abort,
// re-trigger/reset, and a read-latency sweep on two extra instances.
module tb_param_dump_sequencer;

    logic       clk;
    logic       rst;
    logic       dump_req;
    logic       abort;
    logic       tx_ready;
    logic       ready_rand;
    logic       mon_clr;
    logic       dump_req_l;
    logic       lclr;

    logic [2:0] rd_bank_adr;
    logic [5:0] rd_adr;
    logic       rd_en, env_sel, osc_sel, m1_sel, m2_sel, com_sel;
    logic [6:0] rd_data;
    logic [7:0] tx_byte;
    logic       tx_valid, busy, done;

    logic [2:0] bank_1, bank_7;
    logic [5:0] adr_1, adr_7;
    logic       en_1, en_7;
    logic [4:0] sel_1, sel_7;
    logic [6:0] data_1, data_7;
    logic [7:0] byte_1, byte_7;
    logic       valid_1, valid_7, busy_1, busy_7, done_1, done_7;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cnt_0    = 0;
    int cnt_1    = 0;
    int cnt_7    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [7:0] q1[$];
    logic [7:0] q7[$];
    int         c1[$];
    int         c7[$];

    int         hold_err, sel_err, done_cnt, busy_err;
    logic       prev_stall;
    logic [7:0] prev_byte;

    wire [4:0]  sel_vec = {com_sel, m2_sel, m1_sel, osc_sel, env_sel};
    wire [25:0] out_vec = {rd_bank_adr, rd_adr, rd_en, sel_vec, tx_byte, tx_valid, busy, done};

    param_dump_sequencer dut (
        .CLOCK_25(clk), .reset_reg(rst), .dump_req(dump_req), .abort(abort),
        .rd_bank_adr(rd_bank_adr), .rd_adr(rd_adr), .rd_en(rd_en),
        .env_sel(env_sel), .osc_sel(osc_sel), .m1_sel(m1_sel), .m2_sel(m2_sel), .com_sel(com_sel),
        .rd_data(rd_data), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    param_dump_sequencer #(.READ_LAT(1)) dut_l1 (
        .CLOCK_25(clk), .reset_reg(rst), .dump_req(dump_req_l), .abort(1'b0),
        .rd_bank_adr(bank_1), .rd_adr(adr_1), .rd_en(en_1),
        .env_sel(sel_1[0]), .osc_sel(sel_1[1]), .m1_sel(sel_1[2]), .m2_sel(sel_1[3]), .com_sel(sel_1[4]),
        .rd_data(data_1), .tx_byte(byte_1), .tx_valid(valid_1), .tx_ready(1'b1),
        .busy(busy_1), .done(done_1)
    );

    param_dump_sequencer #(.READ_LAT(7)) dut_l7 (
        .CLOCK_25(clk), .reset_reg(rst), .dump_req(dump_req_l), .abort(1'b0),
        .rd_bank_adr(bank_7), .rd_adr(adr_7), .rd_en(en_7),
        .env_sel(sel_7[0]), .osc_sel(sel_7[1]), .m1_sel(sel_7[2]), .m2_sel(sel_7[3]), .com_sel(sel_7[4]),
        .rd_data(data_7), .tx_byte(byte_7), .tx_valid(valid_7), .tx_ready(1'b1),
        .busy(busy_7), .done(done_7)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Parameter value model; returns 7F (never a legal value) until the latency has elapsed.
    function automatic logic [6:0] pval(input logic [2:0] code, input logic [5:0] adr);
        return {code, adr[3:0]};
    endfunction

    assign rd_data = (rd_en && cnt_0 >= 1) ? pval(rd_bank_adr, rd_adr) : 7'h7F;
    assign data_1  = (en_1  && cnt_1 >= 0) ? pval(bank_1, adr_1) : 7'h7F;
    assign data_7  = (en_7  && cnt_7 >= 6) ? pval(bank_7, adr_7) : 7'h7F;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        cnt_0 <= rd_en ? cnt_0 + 1 : 0;
        cnt_1 <= en_1  ? cnt_1 + 1 : 0;
        cnt_7 <= en_7  ? cnt_7 + 1 : 0;
    end

    always @(posedge clk) begin
        #1;
        tx_ready <= ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    function automatic logic [4:0] exp_sel(input logic [2:0] code);
        case (code)
            3'd0:    return 5'b00001;
            3'd1:    return 5'b00010;
            3'd2:    return 5'b00100;
            3'd3:    return 5'b01000;
            3'd5:    return 5'b10000;
            default: return 5'b11111;
        endcase
    endfunction

    // Main-instance monitor: byte capture, hold-stable rule, select rule, done/busy.
    always @(negedge clk) begin
        if (mon_clr) begin
            got.delete();
            hold_err   <= 0;
            sel_err    <= 0;
            done_cnt   <= 0;
            busy_err   <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (tx_valid && tx_ready && !rst) got.push_back(tx_byte);
            if (prev_stall && !rst && (!tx_valid || tx_byte != prev_byte)) hold_err <= hold_err + 1;
            prev_stall <= tx_valid && !tx_ready && !rst;
            prev_byte  <= tx_byte;
            if (rd_en ? (sel_vec != exp_sel(rd_bank_adr)) : (sel_vec != 5'b00000)) sel_err <= sel_err + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (busy) busy_err <= busy_err + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (lclr) begin
            q1.delete(); q7.delete(); c1.delete(); c7.delete();
        end else begin
            if (valid_1 && !rst) begin q1.push_back(byte_1); c1.push_back(cyc); end
            if (valid_7 && !rst) begin q7.push_back(byte_7); c7.push_back(cyc); end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int stream_errs(input logic [7:0] q[$], input int n);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (i >= q.size() || i >= exp_q.size() || q[i] !== exp_q[i]) e++;
        return e;
    endfunction

    function automatic bit is_data(input int p);
        return (p >= 2) && (p < 327) && (((p - 2) % 65) != 0);
    endfunction

    function automatic int gap_errs(input int cq[$], input int spacing);
        int e = 0;
        for (int i = 1; i < cq.size(); i++)
            if (is_data(i) && is_data(i - 1) && (cq[i] - cq[i - 1] != spacing)) e++;
        return e;
    endfunction

    task automatic clear_mon;
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_req(input logic with_abort);
        @(posedge clk); #1 dump_req = 1'b1; abort = with_abort;
        @(posedge clk); #1 dump_req = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [2:0] codes[5];
        int         n;
        logic [7:0] b;
        rst = 1'b1; dump_req = 1'b0; abort = 1'b0; ready_rand = 1'b0;
        mon_clr = 1'b0; lclr = 1'b0; dump_req_l = 1'b0;
        codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h7D);
        foreach (codes[k]) begin
            exp_q.push_back({5'b00000, codes[k]});
            for (int a = 0; a < 64; a++) exp_q.push_back({1'b0, pval(codes[k], 6'(a))});
        end
        exp_q.push_back(8'hF7);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", 32'(out_vec), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("idle_outputs", 32'(out_vec), 32'd0);

        // Basic dump plus a request in the done cycle
        clear_mon();
        pulse_req(1'b0);
        n = 0;
        while (!(tx_valid && tx_ready && tx_byte == 8'hF7) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("f7_seen", {31'd0, tx_valid && tx_byte == 8'hF7}, 32'd1);
        @(posedge clk); #1 dump_req = 1'b1;
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("busy_low_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 dump_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("req_at_done_ignored", {31'd0, busy}, 32'd0);
        check_eq("basic_len", got.size(), 32'd328);
        check_eq("basic_stream", stream_errs(got, 328), 32'd0);
        check_eq("byte0_f0", {24'd0, got[0]}, 32'hF0);
        check_eq("byte1_mfr", {24'd0, got[1]}, 32'h7D);
        check_eq("byte4_env1", {24'd0, got[4]}, 32'h01);
        check_eq("com_header", {24'd0, got[262]}, 32'h05);
        check_eq("com_adr0", {24'd0, got[263]}, 32'h50);
        check_eq("basic_done_cnt", done_cnt, 32'd1);
        check_eq("basic_sel", sel_err, 32'd0);
        check_eq("busy_with_done", busy_err, 32'd0);

        // Backpressure; abort coincident with dump_req in IDLE must be ignored
        clear_mon();
        ready_rand = 1'b1;
        pulse_req(1'b1);
        wait_done("bp_done", 9000);
        ready_rand = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("bp_len", got.size(), 32'd328);
        check_eq("bp_stream", stream_errs(got, 328), 32'd0);
        check_eq("bp_hold", hold_err, 32'd0);
        check_eq("bp_sel", sel_err, 32'd0);

        // Abort while reading osc address 10
        clear_mon();
        pulse_req(1'b0);
        n = 0;
        while (!(rd_en && rd_bank_adr == 3'd1 && rd_adr == 6'd10) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("osc10_reached", {31'd0, rd_en && rd_bank_adr == 3'd1}, 32'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_done("abort_done", 200);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_en) n++;
        end
        b = got[got.size() - 2];
        check_eq("abort_last_data", {31'd0, b == 8'h19 || b == 8'h1A}, 32'd1);
        check_eq("abort_f7", {24'd0, got[got.size() - 1]}, 32'hF7);
        check_eq("abort_done_cnt", done_cnt, 32'd1);
        check_eq("abort_no_rd_en", n, 32'd0);
        check_eq("abort_prefix", stream_errs(got, got.size() - 1), 32'd0);

        // Re-trigger at byte 50, reset at byte 100
        clear_mon();
        pulse_req(1'b0);
        n = 0;
        while (got.size() < 50 && n < 1000) begin @(negedge clk); n++; end
        pulse_req(1'b0);
        n = 0;
        while (got.size() < 100 && n < 1000) begin @(negedge clk); n++; end
        check_eq("reached_100", {31'd0, got.size() >= 100}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("midreset_outputs", 32'(out_vec), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_reset_idle", 32'(out_vec), 32'd0);
        check_eq("retrig_prefix", stream_errs(got, got.size()), 32'd0);
        clear_mon();
        pulse_req(1'b0);
        wait_done("redump_done", 3000);
        repeat (2) @(negedge clk);
        check_eq("redump_len", got.size(), 32'd328);
        check_eq("redump_f0", {24'd0, got[0]}, 32'hF0);
        check_eq("redump_stream", stream_errs(got, 328), 32'd0);

        // Latency sweep on READ_LAT=1 and READ_LAT=7 instances
        @(posedge clk); #1 lclr = 1'b1;
        @(posedge clk); #1 lclr = 1'b0; dump_req_l = 1'b1;
        @(posedge clk); #1 dump_req_l = 1'b0;
        n = 0;
        while (!done_7 && n < 5000) begin @(negedge clk); n++; end
        check_eq("l7_done", {31'd0, done_7}, 32'd1);
        repeat (2) @(negedge clk);
        check_eq("l1_len", q1.size(), 32'd328);
        check_eq("l7_len", q7.size(), 32'd328);
        check_eq("l1_stream", stream_errs(q1, 328), 32'd0);
        check_eq("l7_stream", stream_errs(q7, 328), 32'd0);
        check_eq("l1_gap", c1[4] - c1[3], 32'd2);
        check_eq("l7_gap", c7[4] - c7[3], 32'd8);
        check_eq("l1_all_gaps", gap_errs(c1, 2), 32'd0);
        check_eq("l7_all_gaps", gap_errs(c7, 8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
